// File: rtl/comb_pkg.sv
// comb_pkg: shared state type, frame width and leaf test for the binomial engine
package comb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int frame_w(input int nw);
    return 2 * nw;
  endfunction
  function automatic logic is_leaf(input logic [31:0] n, input logic [31:0] m);
    return m == 0 || m == n;
  endfunction
endpackage

// File: rtl/comb_stack.sv
// comb_stack: LIFO (clk, rst active-low sync, clr/push/pop/split in, d_top/d_new in, top/occ/full/empty out); split rewrites top and pushes d_new
module comb_stack #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic          split,
  input  logic [W-1:0]  d_top,
  input  logic [W-1:0]  d_new,
  output logic [W-1:0]  top,
  output logic [OW-1:0] occ,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wi, ti;
  assign wi = AW'(occ);
  assign ti = AW'(occ - OW'(1));
  assign top = mem[ti];
  assign full = occ == OW'(DEPTH);
  assign empty = occ == '0;
  always_ff @(posedge clk) begin
    if (split) mem[ti] <= d_top;
    if (push || split) mem[wi] <= d_new;
  end
  always_ff @(posedge clk)
    if (!rst || clr) occ <= '0;
    else if (push || split) occ <= occ + OW'(1);
    else if (pop) occ <= occ - OW'(1);
endmodule

// File: rtl/comb_engine.sv
// comb_engine: C(n,m) by stack recursion (clk, rst active-low sync, start/n_in/m_in in; busy/done/result/ovf/inv/stk_err/max_depth out)
module comb_engine
  import comb_pkg::*;
#(
  parameter int NW = 4,
  parameter int CW = 13,
  parameter int DEPTH = 16,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n_in,
  input  logic [NW-1:0] m_in,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] result,
  output logic          ovf,
  output logic          inv,
  output logic          stk_err,
  output logic [OW-1:0] max_depth
);
  localparam int FW = frame_w(NW);
  state_t state, state_n;
  logic [FW-1:0] top, d_top, d_new;
  logic [OW-1:0] occ;
  logic [NW-1:0] tn, tm;
  logic full, empty, leaf, bad, accept, push, pop, split, clr;
  assign tn = top[FW-1:NW];
  assign tm = top[NW-1:0];
  assign leaf = is_leaf(32'(tn), 32'(tm));
  assign bad = m_in > n_in;
  assign accept = state == IDLE && start;
  assign d_top = {tn - NW'(1), tm};
  assign d_new = push ? {n_in, m_in} : {tn - NW'(1), tm - NW'(1)};
  assign busy = state == BUSY;
  assign done = state == DONE;
  comb_stack #(.W(FW), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .split(split),
    .d_top(d_top), .d_new(d_new), .top(top), .occ(occ), .full(full), .empty(empty)
  );
  always_comb begin
    push = accept && !bad;
    pop = busy && leaf;
    split = busy && !leaf && !full;
    clr = busy && !leaf && full;
    state_n = state == IDLE ? (start ? (bad ? DONE : BUSY) : IDLE)
            : state == BUSY ? ((pop && occ == OW'(1)) || clr ? DONE : BUSY)
            : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!rst) begin
      result <= '0;
      ovf <= 1'b0;
      inv <= 1'b0;
      stk_err <= 1'b0;
      max_depth <= '0;
    end else if (accept) begin
      result <= '0;
      ovf <= 1'b0;
      stk_err <= 1'b0;
      inv <= bad;
      max_depth <= bad ? '0 : OW'(1);
    end else if (pop) begin
      result <= &result ? result : result + CW'(1);
      ovf <= ovf | &result;
    end else if (split) begin
      max_depth <= max_depth > occ ? max_depth : occ + OW'(1);
    end else if (clr) begin
      stk_err <= 1'b1;
      result <= '0;
    end
endmodule

// File: tb/tb_comb_engine.sv
// tb_comb_engine: scoreboard bench over default, CW=4 and DEPTH=2 engine instances
module tb_comb_engine;
  typedef struct {
    int res;
    int ovf;
    int inv;
    int err;
    int md;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] start = '0;
  logic [3:0] n_in = '0, m_in = '0;
  logic [2:0] busy, done, ovf, inv, stk_err;
  logic [12:0] r0, r2;
  logic [3:0] r1;
  logic [4:0] md0, md1;
  logic [1:0] md2;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  comb_engine u0 (
    .clk(clk), .rst(rst), .start(start[0]), .n_in(n_in), .m_in(m_in), .busy(busy[0]),
    .done(done[0]), .result(r0), .ovf(ovf[0]), .inv(inv[0]), .stk_err(stk_err[0]), .max_depth(md0)
  );
  comb_engine #(.CW(4)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .n_in(n_in), .m_in(m_in), .busy(busy[1]),
    .done(done[1]), .result(r1), .ovf(ovf[1]), .inv(inv[1]), .stk_err(stk_err[1]), .max_depth(md1)
  );
  comb_engine #(.DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .n_in(n_in), .m_in(m_in), .busy(busy[2]),
    .done(done[2]), .result(r2), .ovf(ovf[2]), .inv(inv[2]), .stk_err(stk_err[2]), .max_depth(md2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] res_of(input int u);
    return u == 0 ? 32'(r0) : u == 1 ? 32'(r1) : 32'(r2);
  endfunction
  function automatic logic [31:0] md_of(input int u);
    return u == 0 ? 32'(md0) : u == 1 ? 32'(md1) : 32'(md2);
  endfunction
  task automatic job(input int u, input int n, input int m, input int cw, input int depth, input bit noise);
    exp_t e, g;
    int c, bc, sat;
    longint b;
    string t;
    sat = (1 << cw) - 1;
    if (m > n) e = '{0, 0, 1, 0, 0, 1};
    else begin
      b = 1;
      for (int i = 0; i < m; i++) b = b * (n - i) / (i + 1);
      e.res = b > sat ? sat : int'(b);
      e.ovf = b > sat ? 1 : 0;
      e.inv = 0;
      e.md = (m == 0 || m == n) ? 1 : m + 1;
      e.lat = int'(2 * b);
      e.err = e.md > depth ? 1 : 0;
      if (e.err == 1) e = '{0, 0, 0, 1, depth, -1};
    end
    q.push_back(e);
    t = $sformatf("u%0d C(%0d,%0d)", u, n, m);
    @(negedge clk);
    n_in = 4'(n);
    m_in = 4'(m);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    c = 1;
    bc = 0;
    while (done[u] !== 1'b1 && c < 2000) begin
      if (busy[u] === 1'b1) bc++;
      if (noise) begin
        start[u] = 1'b1;
        n_in = 4'($urandom);
        m_in = 4'($urandom);
      end
      @(negedge clk);
      c++;
    end
    start[u] = 1'b0;
    g = q.pop_front();
    chk({t, " done seen"}, 32'(done[u]), 1);
    if (g.lat >= 0) begin
      chk({t, " latency"}, c, g.lat);
      chk({t, " busy cycles"}, bc, g.lat - 1);
    end
    chk({t, " busy at done"}, 32'(busy[u]), 0);
    chk({t, " result"}, res_of(u), g.res);
    chk({t, " ovf"}, 32'(ovf[u]), g.ovf);
    chk({t, " inv"}, 32'(inv[u]), g.inv);
    chk({t, " stk_err"}, 32'(stk_err[u]), g.err);
    chk({t, " max_depth"}, md_of(u), g.md);
    @(negedge clk);
    chk({t, " done pulse ends"}, 32'(done[u]), 0);
    chk({t, " result holds"}, res_of(u), g.res);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", res_of(0), 0);
    chk("reset flags", {29'd0, ovf[0], inv[0], stk_err[0]}, 0);
    chk("reset max_depth", md_of(0), 0);
    rst = 1'b1;
    job(0, 4, 2, 13, 16, 0);
    job(0, 5, 0, 13, 16, 0);
    job(0, 7, 7, 13, 16, 0);
    job(0, 5, 2, 13, 16, 0);
    job(0, 2, 3, 13, 16, 0);
    job(0, 3, 1, 13, 16, 0);
    job(0, 15, 15, 13, 16, 0);
    job(1, 8, 4, 4, 16, 0);
    job(1, 6, 2, 4, 16, 0);
    job(2, 4, 2, 13, 2, 0);
    job(2, 3, 1, 13, 2, 0);
    job(0, 5, 2, 13, 16, 1);
    @(negedge clk);
    n_in = 4'd5;
    m_in = 4'd2;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-job busy", 32'(busy[0]), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid reset busy", 32'(busy[0]), 0);
    chk("mid reset done", 32'(done[0]), 0);
    chk("mid reset result", res_of(0), 0);
    chk("mid reset max_depth", md_of(0), 0);
    chk("mid reset flags", {29'd0, ovf[0], inv[0], stk_err[0]}, 0);
    @(negedge clk);
    chk("idle after reset", 32'(busy[0]), 0);
    job(0, 4, 2, 13, 16, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
